// File: rtl/six_bit_serial_subtractor.sv
// rtl/six_bit_serial_subtractor.sv - bit-serial x - y, LSB first, one full-adder slice
// Start/busy/done handshake; z and borrow held until the next completed operation.
module six_bit_serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] xr, yr, sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_bit, load, last;

  // yr holds ~y and carry is seeded with 1, so the slice adds the two's complement
  assign s_bit = xr[0] ^ yr[0] ^ carry;
  assign c_bit = (xr[0] & yr[0]) | (xr[0] & carry) | (yr[0] & carry);
  assign load  = start && (state != RUN);
  assign last  = (state == RUN) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      xr     <= '0;
      yr     <= '0;
      sr     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      z      <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        xr    <= x;
        yr    <= ~y;
        carry <= 1'b1;
        cnt   <= '0;
      end else if (state == RUN) begin
        xr    <= {1'b0, xr[WIDTH-1:1]};
        yr    <= {1'b0, yr[WIDTH-1:1]};
        sr    <= {s_bit, sr[WIDTH-1:1]};
        carry <= c_bit;
        cnt   <= cnt + 1'b1;
        if (last) begin
          z      <= {s_bit, sr[WIDTH-1:1]};
          borrow <= ~c_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_six_bit_serial_subtractor.sv
// tb/tb_six_bit_serial_subtractor.sv - scoreboard bench for six_bit_serial_subtractor
module tb_six_bit_serial_subtractor;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, borrow;
  logic [W-1:0] z;

  typedef struct {
    logic [W-1:0] z;
    logic         b;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  six_bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .borrow(borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int due);
    exp_t e;
    e.z   = W'((a - b) & ((1 << W) - 1));
    e.b   = (a < b);
    e.due = due;
    return e;
  endfunction

  // done must only appear when an expectation is pending, on its due cycle
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("z", z, e.z);
        check("borrow", borrow, e.b);
        check("done_cycle", cyc, e.due);
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input int a, input int b);
    @(negedge clk);
    x = W'(a);
    y = W'(b);
    start = 1'b1;
    sb.push_back(model(a, b, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    wait_empty();
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_borrow", borrow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(13, 5);
    repeat (3) @(negedge clk);
    check("z_hold", z, 8);
    check("borrow_hold", borrow, 0);

    run_op(5, 13);
    run_op(0, 63);
    run_op(63, 63);
    run_op(42, 0);
    run_op(0, 0);

    // operand and start changes while running are ignored
    @(negedge clk);
    x = 6'd20;
    y = 6'd7;
    start = 1'b1;
    sb.push_back(model(20, 7, cyc + 1 + W));
    @(negedge clk);
    x = 6'd1;
    y = 6'd50;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (4) @(negedge clk);

    // back-to-back: second operation accepted in the DONE cycle
    @(negedge clk);
    x = 6'd30;
    y = 6'd10;
    start = 1'b1;
    sb.push_back(model(30, 10, cyc + 1 + W));
    repeat (W + 1) @(negedge clk);
    x = 6'd10;
    y = 6'd30;
    sb.push_back(model(10, 30, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    check("b2b_z_hold", z, 44);

    // reset three cycles into RUN
    repeat (2) @(negedge clk);
    x = 6'd33;
    y = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_z", z, 0);
    check("abort_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_idle", busy, 0);

    run_op(9, 4);

    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/six_bit_serial_subtractor.md
Name: six_bit_serial_subtractor

Overview:
- Computes z = x - y for two 6-bit unsigned operands, one bit per clock, LSB first.
- Uses a single full-adder bit slice with the two's-complement trick: invert y, seed carry-in with 1.
- Companion to the combinational six-bit adder. Used where area matters more than latency.
- Start/busy/done handshake toward the issuing controller; results are held stable until the next operation.

Parameters:
- WIDTH, 6, operand and result width in bits. Counter width is clog2(WIDTH).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new subtraction. Sampled only when the block is idle or done.
- x  input  WIDTH  minuend. Captured on the accepting edge.
- y  input  WIDTH  subtrahend. Captured on the accepting edge.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  single-cycle pulse: z and borrow are valid and new.
- z  output  WIDTH  difference x - y modulo 2^WIDTH. Registered.
- borrow  output  1  1 when x < y (the inverted final carry). Registered.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst_n.
- Reset while rst_n=0:
  - state=IDLE, busy=0, done=0, z=0, borrow=0.
  - Internal operand, shift and counter registers are cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch x into xr and ~y into yr, carry=1, cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1, done=0.
  - Each edge computes s = xr[0]^yr[0]^carry and carry = majority(xr[0], yr[0], carry).
  - Shift s into the MSB of a result shift register. Shift xr and yr right by one. Increment cnt.
  - On the edge where cnt==WIDTH-1: load the completed difference into z, set borrow = ~carry_out, go to DONE.
  - start is ignored in RUN. Operands and outputs are unaffected.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - start=1 at the next edge: accept new operands as in IDLE and go to RUN. done drops, z is still held.
  - Otherwise go to IDLE.
- Latency: if start is accepted at edge k, done is high during the cycle after edge k+WIDTH. That is 6 RUN cycles for WIDTH=6.
- Throughput: one result per WIDTH+1 cycles with start held high.
- Arithmetic is modular with WIDTH-bit wrap-around:
  - x<y gives z = x - y + 2^WIDTH and borrow=1.
  - x>=y gives borrow=0.
  - x==y gives z=0 and borrow=0.
- z and borrow change only on the transition RUN->DONE (or reset). Between operations they hold their last value.
- Changes on x or y after the accepting edge have no effect on the result.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.

Test Plan:
- Reset, then x=13, y=5, start for 1 cycle -> busy high for 6 cycles, then done pulse with z=8, borrow=0. z stays 8 afterwards.
- x=5, y=13 -> z=56, borrow=1. x=0, y=63 -> z=1, borrow=1.
- Edge values: x=63, y=63 -> z=0, borrow=0. x=42, y=0 -> z=42, borrow=0. x=0, y=0 -> z=0, borrow=0.
- Operand and start changes during RUN:
  - Pulse start with x=20, y=7, then drive x=1, y=50, start=1 during RUN.
  - Result z=13, borrow=0.
  - done is asserted exactly once, 6 cycles after acceptance.
- Back-to-back operation:
  - Hold start=1 with operands (30,10), then switch to (10,30) in the DONE cycle.
  - First done gives z=20, borrow=0. The next operation is accepted in DONE.
  - Second done arrives 7 cycles later with z=44, borrow=1.
- Reset mid-operation:
  - Assert rst_n=0 three cycles into RUN -> busy, done, z and borrow go to 0 asynchronously. No done pulse follows.
  - After release, x=9, y=4 -> z=5, borrow=0.
